lc3_trap_stack_ctrl: RTL and testbench
======================================

Name: lc3_trap_stack_ctrl

Overview:
- Sequencer for interrupt entry and RTI on the LC-3 datapath.
- Drives the SP unit controls (SavedUSP/SavedSSP load strobes, SP mux select, SP bus gate) and the bus, register, MAR/MDR, memory, PC and PSR strobes.
- Entry pushes PSR and PC onto the supervisor stack and loads PC from the vector table. RTI pops PC and PSR and restores the user stack.
- Invoked by the main control FSM at instruction boundaries.

Parameters:
- VEC_TABLE_HI, 8'h01, high byte of vector table address (table at x0100).
- PRIV_VECTOR, 8'h00, vector taken on RTI executed in user mode.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- int_req  in  1  interrupt request, level
- int_vector  in  8  vector of the requesting device
- int_priority  in  3  priority of the requesting device
- rti_req  in  1  decoded RTI, level, held until done
- psr_priv  in  1  current PSR[15] (1 = user)
- psr_pri  in  3  current PSR[10:8]
- mem_ready  in  1  memory access complete
- int_ack  out  1  one-cycle accept pulse
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse
- ld_saved_usp  out  1  SavedUSP <= R6
- ld_saved_ssp  out  1  SavedSSP <= R6
- spmux  out  2  00 SavedUSP, 01 R6+1, 10 R6-1, 11 SavedSSP
- gate_sp  out  1  SP unit drives bus
- gate_r6  out  1  R6 drives bus
- ld_r6  out  1  R6 <= bus
- gate_psr  out  1  PSR drives bus
- gate_pc  out  1  PC drives bus
- gate_mdr  out  1  MDR drives bus
- gate_vec  out  1  vector_addr drives bus
- vector_addr  out  16  {VEC_TABLE_HI, latched vector}
- ld_mar  out  1  MAR <= bus
- ld_mdr  out  1  MDR <= bus or memory
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write
- ld_pc  out  1  PC <= bus
- ld_psr  out  1  PSR <= bus
- ld_psr_int  out  1  PSR[15] <= 0, PSR[10:8] <= new_priority
- new_priority  out  3  latched priority

Behaviour:
- Outputs are Moore-decoded from state. Only R_SW additionally depends on psr_priv.
- At most one gate_* is high in any cycle.
- Reset (async): state IDLE; every output 0, including vector_addr and new_priority; latches cleared.
- IDLE acceptance:
  - An interrupt is accepted when int_req = 1 and int_priority > psr_pri (unsigned). int_ack pulses that cycle; vec_q <= int_vector; pri_q <= int_priority.
  - int_req with int_priority <= psr_pri: ignored, remain IDLE, no ack.
  - Accepted interrupt and rti_req in the same cycle: interrupt wins; RTI is re-sampled after done.
  - rti_req with psr_priv = 1: vec_q <= PRIV_VECTOR, pri_q <= psr_pri, take the entry path. No int_ack.
  - rti_req with psr_priv = 0: go to R_MAR1.
- Entry path (user mode starts at I_SW; supervisor mode starts at I_DEC1):
  - I_SW: ld_saved_usp, spmux=11, gate_sp, ld_r6.
  - I_DEC1: spmux=10, gate_sp, ld_r6, ld_mar.
  - I_WPSR: gate_psr, ld_mdr.
  - I_WR1: mem_en, mem_we, held until mem_ready.
  - I_DEC2: spmux=10, gate_sp, ld_r6, ld_mar.
  - I_WPC: gate_pc, ld_mdr.
  - I_WR2: mem_en, mem_we, held until mem_ready.
  - I_VEC: gate_vec, ld_mar, ld_psr_int.
  - I_RD: mem_en, ld_mdr, held until mem_ready.
  - I_LDPC: gate_mdr, ld_pc.
  - DONE.
- RTI path:
  - R_MAR1: gate_r6, ld_mar.
  - R_RD1: mem_en, ld_mdr, held until mem_ready.
  - R_PC: gate_mdr, ld_pc.
  - R_INC1: spmux=01, gate_sp, ld_r6, ld_mar.
  - R_RD2: mem_en, ld_mdr, held until mem_ready.
  - R_PSR: gate_mdr, ld_psr.
  - R_INC2: spmux=01, gate_sp, ld_r6.
  - R_SW: if psr_priv = 1 (restored PSR), assert ld_saved_ssp, spmux=00, gate_sp, ld_r6. Otherwise all strobes 0.
  - DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Memory waits:
  - The state is held with identical outputs while mem_ready = 0.
  - mem_ready = 1 in the first cycle of a wait state advances the FSM at the next edge.
- Latency with zero-wait memory, counted from the accept edge to the done cycle inclusive:
  - Entry: 11 cycles (user) or 10 cycles (supervisor).
  - RTI: 9 cycles.
- Changes to int_req or int_vector after acceptance are ignored.
- Reset mid-sequence aborts immediately; partial stack state is not repaired.
- vector_addr is always {VEC_TABLE_HI, vec_q}; new_priority is always pri_q.

Test Plan:
- Reset with int_req = 1 held: all outputs 0. Release reset with psr_pri = 3, int_priority = 5, int_vector = 8'h80, psr_priv = 1 -> int_ack at the accept edge; I_SW strobes ld_saved_usp + ld_r6 with spmux = 11; vector_addr = x0180 in I_VEC; new_priority = 5; done on cycle 11.
- Supervisor interrupt (psr_priv = 0), mem_ready tied 1 -> no ld_saved_usp; done on cycle 10; exactly two mem_we cycles.
- int_priority = 2, psr_pri = 4 -> no int_ack, busy stays 0 for 20 cycles.
- RTI with psr_priv = 0, restored psr_priv = 1 -> R_SW asserts ld_saved_ssp, spmux = 00, ld_r6; done on cycle 9. Repeat with restored psr_priv = 0 -> R_SW has all strobes 0.
- RTI with psr_priv = 1 -> entry path with vector_addr = x0100, new_priority = psr_pri, no int_ack.
- mem_ready held 0 for 3 cycles in I_WR1 -> mem_en/mem_we held 4 cycles total; reset asserted in I_RD -> all outputs 0 the same cycle, IDLE after release.

Source files
------------

// File: rtl/lc3_trap_stack_ctrl.sv
// lc3_trap_stack_ctrl
//   Sequencer for LC-3 interrupt entry and RTI. The main control FSM hands
//   control to this block at an instruction boundary. It drives the SP unit
//   (SavedUSP/SavedSSP strobes, SP mux, SP bus gate) and the bus, register,
//   MAR/MDR, memory, PC and PSR strobes. Entry pushes PSR then PC onto the
//   supervisor stack and loads PC from the vector table. RTI pops PC then
//   PSR and swaps the user stack back in when the restored PSR is user mode.
// Ports
//   clk, reset              clock, async active-high reset
//   int_req/_vector/_priority  requesting device (level)
//   rti_req                 decoded RTI, held until done
//   psr_priv, psr_pri       current PSR[15], PSR[10:8]
//   mem_ready               memory access complete
//   int_ack, busy, done     handshake / status
//   ld_*, gate_*, spmux, mem_en, mem_we  datapath strobes
//   vector_addr, new_priority  latched vector table address / priority
module lc3_trap_stack_ctrl #(
  parameter logic [7:0] VEC_TABLE_HI = 8'h01,
  parameter logic [7:0] PRIV_VECTOR  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic [7:0]  int_vector,
  input  logic [2:0]  int_priority,
  input  logic        rti_req,
  input  logic        psr_priv,
  input  logic [2:0]  psr_pri,
  input  logic        mem_ready,
  output logic        int_ack,
  output logic        busy,
  output logic        done,
  output logic        ld_saved_usp,
  output logic        ld_saved_ssp,
  output logic [1:0]  spmux,
  output logic        gate_sp,
  output logic        gate_r6,
  output logic        ld_r6,
  output logic        gate_psr,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_vec,
  output logic [15:0] vector_addr,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mem_en,
  output logic        mem_we,
  output logic        ld_pc,
  output logic        ld_psr,
  output logic        ld_psr_int,
  output logic [2:0]  new_priority
);

  typedef enum logic [4:0] {
    IDLE, I_SW, I_DEC1, I_WPSR, I_WR1, I_DEC2, I_WPC, I_WR2, I_VEC, I_RD,
    I_LDPC, R_MAR1, R_RD1, R_PC, R_INC1, R_RD2, R_PSR, R_INC2, R_SW, DONE
  } state_t;

  typedef struct packed {
    logic       usp, ssp;
    logic [1:0] mux;
    logic       gsp, gr6, lr6, gpsr, gpc, gmdr, gvec;
    logic       mar, mdr, men, mwe, lpc, lpsr, lpsri;
  } strb_t;

  localparam logic [1:0] SP_USP = 2'b00, SP_INC = 2'b01,
                         SP_DEC = 2'b10, SP_SSP = 2'b11;

  state_t      state;
  logic [15:0] va_q;
  logic [2:0]  pri_q;
  logic        ack_q;
  strb_t       s;

  wire int_ok = int_req && (int_priority > psr_pri);

  // vector_addr is held as a full register so it reads 0 out of reset and
  // {VEC_TABLE_HI, vector} from the first acceptance onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      va_q  <= '0;
      pri_q <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (int_ok) begin
            // interrupt wins over a simultaneous RTI; RTI stays held and is
            // picked up again once this sequence returns to IDLE
            ack_q <= 1'b1;
            va_q  <= {VEC_TABLE_HI, int_vector};
            pri_q <= int_priority;
            state <= psr_priv ? I_SW : I_DEC1;
          end else if (rti_req) begin
            if (psr_priv) begin
              // RTI in user mode: privilege-violation exception
              va_q  <= {VEC_TABLE_HI, PRIV_VECTOR};
              pri_q <= psr_pri;
              state <= I_SW;
            end else begin
              state <= R_MAR1;
            end
          end
        end
        I_SW:   state <= I_DEC1;
        I_DEC1: state <= I_WPSR;
        I_WPSR: state <= I_WR1;
        I_WR1:  if (mem_ready) state <= I_DEC2;
        I_DEC2: state <= I_WPC;
        I_WPC:  state <= I_WR2;
        I_WR2:  if (mem_ready) state <= I_VEC;
        I_VEC:  state <= I_RD;
        I_RD:   if (mem_ready) state <= I_LDPC;
        I_LDPC: state <= DONE;
        R_MAR1: state <= R_RD1;
        R_RD1:  if (mem_ready) state <= R_PC;
        R_PC:   state <= R_INC1;
        R_INC1: state <= R_RD2;
        R_RD2:  if (mem_ready) state <= R_PSR;
        R_PSR:  state <= R_INC2;
        R_INC2: state <= R_SW;
        R_SW:   state <= DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore strobe decode; R_SW alone looks at psr_priv, which by then is the
  // PSR just popped off the stack.
  always_comb begin
    s = '0;
    case (state)
      I_SW:   begin s.usp = 1'b1; s.mux = SP_SSP; s.gsp = 1'b1; s.lr6 = 1'b1; end
      I_DEC1,
      I_DEC2: begin s.mux = SP_DEC; s.gsp = 1'b1; s.lr6 = 1'b1; s.mar = 1'b1; end
      I_WPSR: begin s.gpsr = 1'b1; s.mdr = 1'b1; end
      I_WR1,
      I_WR2:  begin s.men = 1'b1; s.mwe = 1'b1; end
      I_WPC:  begin s.gpc = 1'b1; s.mdr = 1'b1; end
      I_VEC:  begin s.gvec = 1'b1; s.mar = 1'b1; s.lpsri = 1'b1; end
      I_RD,
      R_RD1,
      R_RD2:  begin s.men = 1'b1; s.mdr = 1'b1; end
      I_LDPC,
      R_PC:   begin s.gmdr = 1'b1; s.lpc = 1'b1; end
      R_MAR1: begin s.gr6 = 1'b1; s.mar = 1'b1; end
      R_INC1: begin s.mux = SP_INC; s.gsp = 1'b1; s.lr6 = 1'b1; s.mar = 1'b1; end
      R_PSR:  begin s.gmdr = 1'b1; s.lpsr = 1'b1; end
      R_INC2: begin s.mux = SP_INC; s.gsp = 1'b1; s.lr6 = 1'b1; end
      R_SW:   if (psr_priv) begin
                s.ssp = 1'b1; s.mux = SP_USP; s.gsp = 1'b1; s.lr6 = 1'b1;
              end
      default: s = '0;
    endcase
  end

  assign int_ack      = ack_q;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign ld_saved_usp = s.usp;
  assign ld_saved_ssp = s.ssp;
  assign spmux        = s.mux;
  assign gate_sp      = s.gsp;
  assign gate_r6      = s.gr6;
  assign ld_r6        = s.lr6;
  assign gate_psr     = s.gpsr;
  assign gate_pc      = s.gpc;
  assign gate_mdr     = s.gmdr;
  assign gate_vec     = s.gvec;
  assign ld_mar       = s.mar;
  assign ld_mdr       = s.mdr;
  assign mem_en       = s.men;
  assign mem_we       = s.mwe;
  assign ld_pc        = s.lpc;
  assign ld_psr       = s.lpsr;
  assign ld_psr_int   = s.lpsri;
  assign vector_addr  = va_q;
  assign new_priority = pri_q;

endmodule

// File: tb/tb_lc3_trap_stack_ctrl.sv
// Self-checking bench for lc3_trap_stack_ctrl. A reference model expands
// each accepted request into the expected per-cycle list of strobe sets and
// the bench walks the DUT through it with random memory wait states.
module tb_lc3_trap_stack_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        int_req = 1'b0, rti_req = 1'b0, psr_priv = 1'b0, mem_ready = 1'b1;
  logic [7:0]  int_vector = '0;
  logic [2:0]  int_priority = '0, psr_pri = '0;
  logic        int_ack, busy, done, ld_saved_usp, ld_saved_ssp;
  logic [1:0]  spmux;
  logic        gate_sp, gate_r6, ld_r6, gate_psr, gate_pc, gate_mdr, gate_vec;
  logic [15:0] vector_addr;
  logic        ld_mar, ld_mdr, mem_en, mem_we, ld_pc, ld_psr, ld_psr_int;
  logic [2:0]  new_priority;

  lc3_trap_stack_ctrl dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_vector(int_vector),
    .int_priority(int_priority), .rti_req(rti_req), .psr_priv(psr_priv),
    .psr_pri(psr_pri), .mem_ready(mem_ready), .int_ack(int_ack), .busy(busy),
    .done(done), .ld_saved_usp(ld_saved_usp), .ld_saved_ssp(ld_saved_ssp),
    .spmux(spmux), .gate_sp(gate_sp), .gate_r6(gate_r6), .ld_r6(ld_r6),
    .gate_psr(gate_psr), .gate_pc(gate_pc), .gate_mdr(gate_mdr),
    .gate_vec(gate_vec), .vector_addr(vector_addr), .ld_mar(ld_mar),
    .ld_mdr(ld_mdr), .mem_en(mem_en), .mem_we(mem_we), .ld_pc(ld_pc),
    .ld_psr(ld_psr), .ld_psr_int(ld_psr_int), .new_priority(new_priority)
  );

  always #5 clk = ~clk;

  typedef logic [20:0] ow_t;
  localparam ow_t ACK = 21'(1) << 20, BSY = 21'(1) << 19, DN = 21'(1) << 18;
  localparam ow_t USP = 21'(1) << 17, SSP = 21'(1) << 16;
  localparam ow_t GSP = 21'(1) << 13, GR6 = 21'(1) << 12, LR6 = 21'(1) << 11;
  localparam ow_t GPSR = 21'(1) << 10, GPC = 21'(1) << 9, GMDR = 21'(1) << 8;
  localparam ow_t GVEC = 21'(1) << 7, MAR = 21'(1) << 6, MDR = 21'(1) << 5;
  localparam ow_t MEN = 21'(1) << 4, MWE = 21'(1) << 3, LPC = 21'(1) << 2;
  localparam ow_t LPSR = 21'(1) << 1, LPSRI = 21'(1);

  int vectors = 0, errors = 0;
  ow_t exp_q[$];
  bit  wait_q[$];
  logic [15:0] exp_va = '0;
  logic [2:0]  exp_np = '0;

  function automatic ow_t sp(input int m);
    return ow_t'(m) << 14;
  endfunction

  function automatic ow_t obs();
    return {int_ack, busy, done, ld_saved_usp, ld_saved_ssp, spmux, gate_sp,
            gate_r6, ld_r6, gate_psr, gate_pc, gate_mdr, gate_vec, ld_mar,
            ld_mdr, mem_en, mem_we, ld_pc, ld_psr, ld_psr_int};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input ow_t w, input bit wt);
    exp_q.push_back(w | BSY);
    wait_q.push_back(wt);
  endtask

  // Entry: push PSR, push PC, fetch handler address from the table.
  task automatic build_entry(input bit user);
    if (user) push(USP | sp(3) | GSP | LR6, 0);
    push(sp(2) | GSP | LR6 | MAR, 0);
    push(GPSR | MDR, 0);
    push(MEN | MWE, 1);
    push(sp(2) | GSP | LR6 | MAR, 0);
    push(GPC | MDR, 0);
    push(MEN | MWE, 1);
    push(GVEC | MAR | LPSRI, 0);
    push(MEN | MDR, 1);
    push(GMDR | LPC, 0);
    push(DN, 0);
  endtask

  // RTI: pop PC, pop PSR, swap back to the user stack if returning to user.
  task automatic build_rti(input bit to_user);
    push(GR6 | MAR, 0);
    push(MEN | MDR, 1);
    push(GMDR | LPC, 0);
    push(sp(1) | GSP | LR6 | MAR, 0);
    push(MEN | MDR, 1);
    push(GMDR | LPSR, 0);
    push(sp(1) | GSP | LR6, 0);
    push(to_user ? (SSP | sp(0) | GSP | LR6) : ow_t'(0), 0);
    push(DN, 0);
  endtask

  function automatic int pick(input int waits);
    return (waits < 0) ? int'($urandom_range(0, 2)) : waits;
  endfunction

  // One request from IDLE. waits<0 gives random wait states; abort_idx>=0
  // fires reset during that step of the expected trace.
  task automatic run(input logic ireq, input logic [7:0] ivec, input logic [2:0] iprio,
                     input logic rti, input logic priv, input logic [2:0] ppri,
                     input logic rest_priv, input int waits, input int abort_idx);
    bit accept, ack, is_rti;
    int idx, wleft, we_exp, we_obs;
    int_req = ireq; int_vector = ivec; int_priority = iprio;
    rti_req = rti; psr_priv = priv; psr_pri = ppri;
    accept = ireq && (iprio > ppri);
    ack = accept;
    is_rti = 0;
    exp_q.delete(); wait_q.delete();
    if (accept) begin
      build_entry(priv); exp_va = {8'h01, ivec}; exp_np = iprio;
    end else if (rti && priv) begin
      build_entry(1'b1); exp_va = 16'h0100; exp_np = ppri;
    end else if (rti) begin
      build_rti(rest_priv); is_rti = 1;
    end else begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ack", int_ack, 0);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    idx = 0; wleft = 0; we_exp = 0; we_obs = 0;
    while (idx < exp_q.size()) begin
      // post-acceptance request changes must not matter
      int_req = 1'($urandom); int_vector = 8'($urandom); int_priority = 3'($urandom);
      psr_pri = 3'($urandom);
      psr_priv = is_rti ? rest_priv : 1'($urandom);
      mem_ready = wait_q[idx] ? (wleft == 0) : 1'($urandom);
      @(negedge clk);
      chk("trace", obs(), exp_q[idx] | ((idx == 0 && ack) ? ACK : ow_t'(0)));
      chk("vector_addr", vector_addr, exp_va);
      chk("new_priority", new_priority, exp_np);
      if ((exp_q[idx] & MWE) != 0) we_exp++;
      if (mem_we) we_obs++;
      if (idx == abort_idx) begin
        #2 reset = 1'b1;
        #1 chk("abort_outs", obs(), 0);
        chk("abort_va", vector_addr, 0);
        chk("abort_np", new_priority, 0);
        exp_va = '0; exp_np = '0;
        int_req = 0; rti_req = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        return;
      end
      if (wait_q[idx] && wleft > 0) wleft--;
      else begin
        idx++;
        if (idx < exp_q.size() && wait_q[idx]) wleft = pick(waits);
      end
      @(posedge clk); #1;
    end
    chk("mem_we_cycles", we_obs, we_exp);
    int_req = 0;
    if (is_rti || (rti && priv)) rti_req = 0;
  endtask

  initial begin
    // reset with a qualifying interrupt held
    int_req = 1; int_priority = 5; int_vector = 8'h80; psr_pri = 3; psr_priv = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", obs(), 0);
    chk("reset_va", vector_addr, 0);
    chk("reset_np", new_priority, 0);
    @(posedge clk); #1 reset = 1'b0;
    // user interrupt, 11-cycle entry, vector x0180, priority 5
    run(1, 8'h80, 5, 0, 1, 3, 0, 0, -1);
    // supervisor interrupt with zero-wait memory: 10 cycles, two writes
    run(1, 8'h42, 6, 0, 0, 2, 0, 0, -1);
    // low priority request ignored for 20 cycles
    int_req = 1; int_priority = 2; psr_pri = 4; rti_req = 0; psr_priv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("low_pri_busy", busy, 0);
      chk("low_pri_ack", int_ack, 0);
    end
    @(posedge clk); #1 int_req = 0;
    // RTI back to user, then back to supervisor
    run(0, 8'h00, 0, 1, 0, 2, 1, 0, -1);
    run(0, 8'h00, 0, 1, 0, 2, 0, 0, -1);
    // RTI in user mode -> privilege vector x0100, priority = psr_pri
    run(0, 8'h33, 0, 1, 1, 6, 0, 0, -1);
    // interrupt and RTI together: interrupt first, RTI after done
    run(1, 8'h21, 7, 1, 0, 1, 0, 0, -1);
    run(0, 8'h00, 0, 1, 0, 1, 1, 0, -1);
    // three-cycle memory stalls in every wait state
    run(1, 8'h90, 4, 0, 1, 0, 0, 3, -1);
    // reset hits during the vector table read (I_RD is step 8 of user entry)
    run(1, 8'h55, 3, 0, 1, 1, 0, 0, 8);
    // random mix
    for (int t = 0; t < 40; t++) begin
      logic r;
      r = 1'($urandom);
      run(1'($urandom), 8'($urandom), 3'($urandom), r, 1'($urandom), 3'($urandom),
          1'($urandom), -1, -1);
    end
    int_req = 0; rti_req = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
